// File: rtl/lsu_wb.sv
// Load/store unit with a single-outstanding Wishbone-style bus port.
//
// Accepts one instruction per cycle from EX. Non-memory instructions are
// written back with one cycle of latency. Aligned loads and stores move to
// the BUS state, where the access is held on the bus until ack or timeout.
// Misaligned accesses raise exc_align and never reach the bus.
// Byte order is big-endian: byte offset 0 is bits 31:24.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   ex_*               instruction from EX (valid, wreg, wd, wdata, memop,
//                      mem_addr, store_data)
//   bus_req/we/addr/sel/wdata   bus request (held stable while in BUS)
//   bus_ack, bus_rdata          bus response (ack ignored outside BUS)
//   stall_req          combinational hold for EX/upstream
//   wb_we/waddr/wdata  register-file write port
//   exc_align, bus_err one-cycle pulses for misalignment and bus timeout
module lsu_wb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_req,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        exc_align,
  output logic        bus_err
);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  // Counter value seen in the last permitted BUS cycle.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic {StIdle, StBus} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_sdata;
  logic [4:0]  r_wd;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_wb_we, w_wb_we_nxt;
  logic [4:0]  r_wb_waddr, w_wb_waddr_nxt;
  logic [31:0] r_wb_wdata, w_wb_wdata_nxt;
  logic        r_exc, w_exc_nxt;
  logic        r_err, w_err_nxt;
  logic        w_latch;

  logic        w_is_load, w_is_store, w_is_mem, w_aligned;
  logic        w_r_is_load, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  // Decode of the incoming instruction.
  assign w_is_load  = (ex_memop >= OpLb) && (ex_memop <= OpLw);
  assign w_is_store = (ex_memop >= OpSb) && (ex_memop <= OpSw);
  assign w_is_mem   = w_is_load | w_is_store;

  always_comb begin
    w_aligned = 1'b1;
    case (ex_memop)
      OpLh, OpLhu, OpSh: w_aligned = ~ex_mem_addr[0];
      OpLw, OpSw:        w_aligned = (ex_mem_addr[1:0] == 2'b00);
      default:           w_aligned = 1'b1;
    endcase
  end

  assign w_r_is_load = (r_op >= OpLb) && (r_op <= OpLw);
  assign w_timeout   = (r_state == StBus) && (r_cnt == CntLast);

  // Bus request: driven from latched state so it stays stable for the access.
  assign bus_req  = (r_state == StBus);
  assign bus_addr = bus_req ? {r_addr[31:2], 2'b00} : 32'h0;

  always_comb begin
    bus_we    = 1'b0;
    bus_sel   = 4'b0000;
    bus_wdata = 32'h0;
    if (r_state == StBus) begin
      case (r_op)
        OpSb: begin
          bus_we    = 1'b1;
          bus_wdata = {4{r_sdata[7:0]}};
          bus_sel   = 4'b1000 >> r_addr[1:0];
        end
        OpSh: begin
          bus_we    = 1'b1;
          bus_wdata = {2{r_sdata[15:0]}};
          bus_sel   = r_addr[1] ? 4'b0011 : 4'b1100;
        end
        OpSw: begin
          bus_we    = 1'b1;
          bus_wdata = r_sdata;
          bus_sel   = 4'b1111;
        end
        default: bus_sel = 4'b1111;
      endcase
    end
  end

  // Lane extraction for loads (big-endian).
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus_rdata[31:24];
      2'd1:    w_byte = bus_rdata[23:16];
      2'd2:    w_byte = bus_rdata[15:8];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (r_op)
      OpLb:    w_load_val = {{24{w_byte[7]}}, w_byte};
      OpLbu:   w_load_val = {24'h0, w_byte};
      OpLh:    w_load_val = {{16{w_half[15]}}, w_half};
      OpLhu:   w_load_val = {16'h0, w_half};
      default: w_load_val = bus_rdata;
    endcase
  end

  // Gated by rst so the hold reads 0 while reset is asserted.
  assign stall_req = rst & (((r_state == StIdle) & ex_valid & w_is_mem & w_aligned) |
                            ((r_state == StBus) & ~bus_ack & ~w_timeout));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_latch        = 1'b0;
    w_wb_we_nxt    = 1'b0;
    w_wb_waddr_nxt = r_wb_waddr;
    w_wb_wdata_nxt = r_wb_wdata;
    w_exc_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      StIdle: begin
        if (ex_valid) begin
          if (w_is_mem) begin
            if (w_aligned) begin
              w_state_nxt = StBus;
              w_cnt_nxt   = 8'd0;
              w_latch     = 1'b1;
            end else begin
              w_exc_nxt = 1'b1;
            end
          end else begin
            w_wb_we_nxt    = ex_wreg && (ex_wd != 5'd0);
            w_wb_waddr_nxt = ex_wd;
            w_wb_wdata_nxt = ex_wdata;
          end
        end
      end
      StBus: begin
        // Ack wins over a timeout in the same cycle.
        if (bus_ack) begin
          w_state_nxt = StIdle;
          if (w_r_is_load) begin
            w_wb_we_nxt    = (r_wd != 5'd0);
            w_wb_waddr_nxt = r_wd;
            w_wb_wdata_nxt = w_load_val;
          end
        end else if (w_timeout) begin
          w_state_nxt = StIdle;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= 4'd0;
      r_addr  <= 32'h0;
      r_sdata <= 32'h0;
      r_wd    <= 5'd0;
    end else if (w_latch) begin
      r_op    <= ex_memop;
      r_addr  <= ex_mem_addr;
      r_sdata <= ex_store_data;
      r_wd    <= ex_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_we    <= 1'b0;
      r_wb_waddr <= 5'd0;
      r_wb_wdata <= 32'h0;
      r_exc      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wb_we    <= w_wb_we_nxt;
      r_wb_waddr <= w_wb_waddr_nxt;
      r_wb_wdata <= w_wb_wdata_nxt;
      r_exc      <= w_exc_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign wb_we     = r_wb_we;
  assign wb_waddr  = r_wb_waddr;
  assign wb_wdata  = r_wb_wdata;
  assign exc_align = r_exc;
  assign bus_err   = r_err;

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb (TIMEOUT=4): directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the unit.
module tb_lsu_wb;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_mem_addr, ex_store_data;
  logic [3:0]  ex_memop;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        stall_req, wb_we, exc_align, bus_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int vectors = 0;
  int errors  = 0;

  lsu_wb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_req(stall_req), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .exc_align(exc_align), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_busy;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_wd;
  int          m_waited;
  logic        e_we, e_exc, e_err;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic is_aligned(input logic [3:0] op, input logic [31:0] addr);
    int unsigned size;
    size = (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 :
           (op == 4'd5 || op == 4'd8) ? 4 : 1;
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    int unsigned off;
    logic [31:0] b, h;
    off = addr % 4;
    b = (rd >> (8 * (3 - off))) & 32'hFF;
    h = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
    case (op)
      4'd1:    return b[7] ? (b | 32'hFFFFFF00) : b;
      4'd2:    return b;
      4'd3:    return h[15] ? (h | 32'hFFFF0000) : h;
      4'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (op == 4'd6) return 4'b0001 << (3 - off);
    if (op == 4'd7) return 4'b0011 << (2 * (1 - off / 2));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_bwdata(input logic [3:0] op, input logic [31:0] d);
    if (op == 4'd6) return (d & 32'hFF) * 32'h01010101;
    if (op == 4'd7) return (d & 32'hFFFF) * 32'h00010001;
    if (op == 4'd8) return d;
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_op = 4'd0; m_addr = 32'h0; m_data = 32'h0; m_wd = 5'd0;
    m_waited = 0;
    e_we = 1'b0; e_exc = 1'b0; e_err = 1'b0; e_waddr = 5'd0; e_wdata = 32'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all DUT outputs with what the model says they must be now.
  task automatic model_check();
    logic last;
    last = m_busy && (m_waited + 1 == int'(TO));
    chk("bus_req",   bus_req,   m_busy);
    chk("bus_addr",  bus_addr,  m_busy ? (m_addr & 32'hFFFFFFFC) : 32'h0);
    chk("bus_we",    bus_we,    m_busy && is_store(m_op));
    chk("bus_sel",   bus_sel,   m_busy ? exp_sel(m_op, m_addr) : 4'b0);
    chk("bus_wdata", bus_wdata, m_busy ? exp_bwdata(m_op, m_data) : 32'h0);
    chk("stall_req", stall_req,
        rst && ((!m_busy && ex_valid && (is_load(ex_memop) || is_store(ex_memop)) &&
                 is_aligned(ex_memop, ex_mem_addr)) ||
                (m_busy && !bus_ack && !last)));
    chk("wb_we",     wb_we,     e_we);
    if (e_we) begin
      chk("wb_waddr", wb_waddr, e_waddr);
      chk("wb_wdata", wb_wdata, e_wdata);
    end
    chk("exc_align", exc_align, e_exc);
    chk("bus_err",   bus_err,   e_err);
  endtask

  // What the clock edge does, given current inputs.
  task automatic model_advance();
    e_we = 1'b0; e_exc = 1'b0; e_err = 1'b0;
    if (m_busy) begin
      if (bus_ack) begin
        m_busy = 1'b0;
        if (is_load(m_op)) begin
          e_we    = (m_wd != 0);
          e_waddr = m_wd;
          e_wdata = exp_load(m_op, m_addr, bus_rdata);
        end
      end else if (m_waited + 1 == int'(TO)) begin
        m_busy = 1'b0;
        e_err  = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (ex_valid) begin
      if (is_load(ex_memop) || is_store(ex_memop)) begin
        if (is_aligned(ex_memop, ex_mem_addr)) begin
          m_busy = 1'b1; m_waited = 0; m_op = ex_memop;
          m_addr = ex_mem_addr; m_data = ex_store_data; m_wd = ex_wd;
        end else begin
          e_exc = 1'b1;
        end
      end else begin
        e_we    = ex_wreg && (ex_wd != 0);
        e_waddr = ex_wd;
        e_wdata = ex_wdata;
      end
    end
  endtask

  // One clock cycle: check at the falling edge, then step past the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic wr, input logic [4:0] wd,
                        input logic [31:0] wdat, input logic [3:0] op,
                        input logic [31:0] addr, input logic [31:0] sd);
    ex_valid = v; ex_wreg = wr; ex_wd = wd; ex_wdata = wdat;
    ex_memop = op; ex_mem_addr = addr; ex_store_data = sd;
  endtask

  initial begin
    int n;
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    set_ex(1'b1, 1'b1, 5'd1, 32'h0, 4'd5, 32'h100, 32'h0);
    model_reset();
    #3;
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_stall",   stall_req, 1'b0);
    chk("rst_wb_we",   wb_we, 1'b0);
    chk("rst_exc",     exc_align, 1'b0);
    chk("rst_err",     bus_err, 1'b0);
    @(posedge clk); #1;
    set_ex(1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 32'h0, 32'h0);
    rst = 1'b1;
    step();

    // ALU writeback, then rd=0 suppression.
    set_ex(1'b1, 1'b1, 5'd3, 32'h12345678, 4'd0, 32'h0, 32'h0);
    step();
    set_ex(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 4'd0, 32'h0, 32'h0);
    chk("alu_we",    wb_we, 1'b1);
    chk("alu_waddr", wb_waddr, 5'd3);
    chk("alu_wdata", wb_wdata, 32'h12345678);
    step();
    ex_valid = 1'b0;
    chk("alu_rd0_we", wb_we, 1'b0);

    // LB / LBU at 0x1001, ack after two wait cycles.
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 1'b1, 5'd7, 32'h0, (k == 0) ? 4'd1 : 4'd2, 32'h1001, 32'h0);
      n = 0;
      #1 if (stall_req) n++;
      step();
      ex_valid = 1'b0;
      chk("lb_addr", bus_addr, 32'h1000);
      chk("lb_sel",  bus_sel, 4'b1111);
      if (stall_req) n++;
      step();
      if (stall_req) n++;
      step();
      bus_ack = 1'b1; bus_rdata = 32'h11F02233;
      #1 if (stall_req) n++;
      step();
      bus_ack = 1'b0;
      chk("lb_stall_cycles", n, 3);
      chk("lb_we",    wb_we, 1'b1);
      chk("lb_wdata", wb_wdata, (k == 0) ? 32'hFFFFFFF0 : 32'h000000F0);
      step();
    end

    // SH at 0x2002.
    set_ex(1'b1, 1'b1, 5'd9, 32'h0, 4'd7, 32'h2002, 32'h0000BEEF);
    step();
    ex_valid = 1'b0;
    chk("sh_we",    bus_we, 1'b1);
    chk("sh_sel",   bus_sel, 4'b0011);
    chk("sh_wdata", bus_wdata, 32'hBEEFBEEF);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("sh_no_wb", wb_we, 1'b0);

    // Misaligned LW.
    set_ex(1'b1, 1'b1, 5'd4, 32'h0, 4'd5, 32'h3002, 32'h0);
    #1 chk("mis_stall", stall_req, 1'b0);
    step();
    ex_valid = 1'b0;
    chk("mis_exc",  exc_align, 1'b1);
    chk("mis_req",  bus_req, 1'b0);
    chk("mis_wb",   wb_we, 1'b0);
    step();
    chk("mis_exc_pulse", exc_align, 1'b0);

    // Timeout with no ack.
    set_ex(1'b1, 1'b1, 5'd4, 32'h0, 4'd8, 32'h4000, 32'h55AA55AA);
    step();
    ex_valid = 1'b0;
    n = 0;
    while (bus_req && n < 20) begin
      n++;
      if (n == 4) chk("to_stall_last", stall_req, 1'b0);
      step();
    end
    chk("to_req_cycles", n, 4);
    chk("to_err", bus_err, 1'b1);
    chk("to_wb",  wb_we, 1'b0);
    step();

    // Ack in the last permitted cycle wins.
    set_ex(1'b1, 1'b1, 5'd5, 32'h0, 4'd5, 32'h5000, 32'h0);
    step();
    ex_valid = 1'b0;
    step(); step(); step();
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1 chk("ackto_stall", stall_req, 1'b0);
    step();
    bus_ack = 1'b0;
    chk("ackto_err",   bus_err, 1'b0);
    chk("ackto_we",    wb_we, 1'b1);
    chk("ackto_wdata", wb_wdata, 32'hCAFEF00D);
    chk("ackto_req",   bus_req, 1'b0);

    // Reset in the middle of a bus access; late ack must be ignored.
    set_ex(1'b1, 1'b1, 5'd6, 32'h0, 4'd5, 32'h6000, 32'h0);
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_req",   bus_req, 1'b0);
    chk("mid_rst_stall", stall_req, 1'b0);
    chk("mid_rst_wb",    wb_we, 1'b0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h01020304;
    step();
    bus_ack = 1'b0;
    chk("late_ack_wb", wb_we, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_ex(($urandom % 4) != 0, 1'($urandom), 5'($urandom), $urandom,
             4'($urandom), $urandom, $urandom);
      bus_ack   = ($urandom % 3) == 0;
      bus_rdata = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
